// File: rtl/alarm_pkg.sv
// Shared types and default widths for the alarm sounder slice.
// Holds the controller state encoding and the snooze-count width.
package alarm_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StBeep   = 2'd1,
        StSnooze = 2'd2,
        StDone   = 2'd3
    } alarm_state_e;

    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned SNZ_W_DEF = 10;
    localparam int unsigned SNZ_CNT_W = 3;

    function automatic logic is_sounding(input alarm_state_e s);
        return (s == StBeep) || (s == StSnooze);
    endfunction

endpackage

// File: rtl/beep_pattern_gen.sv
// ON/OFF beep pattern: phase counter plus registered beep drive.
// restart starts a fresh cycle with the tone on; enable low silences and rewinds.
module beep_pattern_gen
    import alarm_pkg::*;
#(
    parameter int unsigned ON_TICKS  = 1,
    parameter int unsigned OFF_TICKS = 1,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    input  logic tick,
    output logic beep
);

    localparam logic [CNT_W-1:0] OnEnd  = CNT_W'(ON_TICKS);
    localparam logic [CNT_W-1:0] Period = CNT_W'(ON_TICKS + OFF_TICKS);

    logic [CNT_W-1:0] phase_q, phase_d, phase_inc;
    logic             beep_q, beep_d;

    always_comb begin
        phase_d   = phase_q;
        beep_d    = beep_q;
        phase_inc = phase_q + CNT_W'(1);
        if (restart) begin
            phase_d = '0;
            beep_d  = 1'b1;
        end else if (!enable) begin
            phase_d = '0;
            beep_d  = 1'b0;
        end else if (tick) begin
            if (phase_inc == Period) begin
                phase_d = '0;
                beep_d  = 1'b1;
            end else begin
                phase_d = phase_inc;
                if (phase_inc == OnEnd) begin
                    beep_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= '0;
            beep_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            beep_q  <= beep_d;
        end
    end

    assign beep = beep_q;

endmodule

// File: rtl/alarm_beep_ctrl.sv
// Alarm sounder: timed patterned ring on trigger rise, with stop, limited snooze and re-ring.
// Define ALARM_BEEP_ESCALATE_EN to hold a continuous tone over the second half of each ring.
module alarm_beep_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned DURATION     = 60,
    parameter int unsigned ON_TICKS     = 1,
    parameter int unsigned OFF_TICKS    = 1,
    parameter int unsigned SNZ_W        = SNZ_W_DEF,
    parameter int unsigned SNOOZE_TICKS = 300,
    parameter int unsigned MAX_SNOOZE   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 trigger,
    input  logic                 stop,
    input  logic                 snooze,
    output logic                 beeping,
    output logic                 active,
    output logic                 snoozing,
    output logic                 auto_reset,
    output logic [SNZ_CNT_W-1:0] snooze_cnt
);

    localparam logic [CNT_W-1:0]     DurLast = CNT_W'(DURATION - 1);
    localparam logic [SNZ_W-1:0]     SnzLast = SNZ_W'(SNOOZE_TICKS - 1);
    localparam logic [SNZ_CNT_W-1:0] MaxSnz  = SNZ_CNT_W'(MAX_SNOOZE);

    alarm_state_e         state_q, state_d;
    logic                 trig_q;
    logic [CNT_W-1:0]     elapsed_q, elapsed_d;
    logic [SNZ_W-1:0]     snz_q, snz_d;
    logic [SNZ_CNT_W-1:0] snooze_cnt_q, snooze_cnt_d;
    logic                 auto_reset_q, auto_reset_d;
    logic                 active_q, active_d;
    logic                 snoozing_q, snoozing_d;

    logic rise, ring_end, snz_end;
    logic pat_restart, pat_enable, pat_beep;

    assign rise     = trigger & ~trig_q;
    assign ring_end = tick && (elapsed_q == DurLast);
    assign snz_end  = tick && (snz_q == SnzLast);

    // Priority within a cycle: trigger low, then stop, then ring end, then snooze.
    always_comb begin
        state_d      = state_q;
        elapsed_d    = elapsed_q;
        snz_d        = snz_q;
        snooze_cnt_d = snooze_cnt_q;
        auto_reset_d = 1'b0;
        case (state_q)
            StIdle: begin
                snooze_cnt_d = '0;
                if (rise) begin
                    state_d   = StBeep;
                    elapsed_d = '0;
                end
            end
            StBeep: begin
                if (!trigger) begin
                    state_d      = StIdle;
                    snooze_cnt_d = '0;
                end else if (stop || ring_end) begin
                    state_d      = StDone;
                    auto_reset_d = 1'b1;
                end else if (snooze && (snooze_cnt_q < MaxSnz)) begin
                    state_d      = StSnooze;
                    snz_d        = '0;
                    snooze_cnt_d = snooze_cnt_q + SNZ_CNT_W'(1);
                end else if (tick) begin
                    elapsed_d = elapsed_q + CNT_W'(1);
                end
            end
            StSnooze: begin
                if (!trigger) begin
                    state_d      = StIdle;
                    snooze_cnt_d = '0;
                end else if (stop) begin
                    state_d      = StDone;
                    auto_reset_d = 1'b1;
                end else if (snz_end) begin
                    state_d   = StBeep;
                    elapsed_d = '0;
                end else if (tick) begin
                    snz_d = snz_q + SNZ_W'(1);
                end
            end
            StDone: begin
                if (!trigger) begin
                    state_d      = StIdle;
                    snooze_cnt_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        active_d   = is_sounding(state_d);
        snoozing_d = (state_d == StSnooze);
    end

    // Pattern restarts on every entry into BEEP and only runs while BEEP persists.
    assign pat_restart = (state_d == StBeep) && (state_q != StBeep);
    assign pat_enable  = (state_d == StBeep) && (state_q == StBeep);

    beep_pattern_gen #(
        .ON_TICKS (ON_TICKS),
        .OFF_TICKS(OFF_TICKS),
        .CNT_W    (CNT_W)
    ) u_pattern (
        .clk    (clk),
        .reset  (reset),
        .restart(pat_restart),
        .enable (pat_enable),
        .tick   (tick),
        .beep   (pat_beep)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            trig_q       <= 1'b0;
            elapsed_q    <= '0;
            snz_q        <= '0;
            snooze_cnt_q <= '0;
            auto_reset_q <= 1'b0;
            active_q     <= 1'b0;
            snoozing_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            trig_q       <= trigger;
            elapsed_q    <= elapsed_d;
            snz_q        <= snz_d;
            snooze_cnt_q <= snooze_cnt_d;
            auto_reset_q <= auto_reset_d;
            active_q     <= active_d;
            snoozing_q   <= snoozing_d;
        end
    end

`ifdef ALARM_BEEP_ESCALATE_EN
    localparam logic [CNT_W-1:0] EscStart = CNT_W'(DURATION / 2);

    logic esc_q, esc_d;

    always_comb begin
        esc_d = (state_d == StBeep) && (elapsed_d >= EscStart);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            esc_q <= 1'b0;
        end else begin
            esc_q <= esc_d;
        end
    end

    assign beeping = pat_beep | esc_q;
`else
    assign beeping = pat_beep;
`endif

    assign active     = active_q;
    assign snoozing   = snoozing_q;
    assign auto_reset = auto_reset_q;
    assign snooze_cnt = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_beep_ctrl.sv
// Randomized bench for alarm_beep_ctrl against a tick-counting behavioural model,
// plus directed scenarios with hand-computed expectations.
module tb_alarm_beep_ctrl;

    localparam int unsigned DUR  = 6;
    localparam int unsigned ON   = 1;
    localparam int unsigned OFF  = 1;
    localparam int unsigned SNZ  = 4;
    localparam int unsigned MAXS = 2;

    logic       clk = 1'b0;
    logic       reset, tick, trigger, stop, snooze;
    logic       beeping, active, snoozing, auto_reset;
    logic [2:0] snooze_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: mode 0 idle, 1 ringing, 2 snoozing, 3 done; ring_ticks counts ticks into the ring.
    int m_mode, ring_ticks, snz_ticks, snz_used;
    bit m_trig, m_ar;

    always #5 clk = ~clk;

    alarm_beep_ctrl #(
        .CNT_W       (8),
        .DURATION    (DUR),
        .ON_TICKS    (ON),
        .OFF_TICKS   (OFF),
        .SNZ_W       (10),
        .SNOOZE_TICKS(SNZ),
        .MAX_SNOOZE  (MAXS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .trigger   (trigger),
        .stop      (stop),
        .snooze    (snooze),
        .beeping   (beeping),
        .active    (active),
        .snoozing  (snoozing),
        .auto_reset(auto_reset),
        .snooze_cnt(snooze_cnt)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_beep();
        if (m_mode != 1) return 1'b0;
`ifdef ALARM_BEEP_ESCALATE_EN
        if (ring_ticks >= int'(DUR / 2)) return 1'b1;
`endif
        return (ring_ticks % (ON + OFF)) < ON;
    endfunction

    task automatic model_step();
        bit rise;
        if (reset) begin
            m_mode = 0; ring_ticks = 0; snz_ticks = 0; snz_used = 0; m_trig = 0; m_ar = 0;
            return;
        end
        rise = trigger && !m_trig;
        m_ar = 0;
        if (m_mode != 0 && !trigger) begin
            m_mode = 0;
            snz_used = 0;
        end else begin
            case (m_mode)
                0: if (rise) begin m_mode = 1; ring_ticks = 0; end
                1: begin
                    if (stop || (tick && ring_ticks == int'(DUR) - 1)) begin
                        m_mode = 3; m_ar = 1;
                    end else if (snooze && snz_used < int'(MAXS)) begin
                        m_mode = 2; snz_ticks = 0; snz_used++;
                    end else if (tick) begin
                        ring_ticks++;
                    end
                end
                2: begin
                    if (stop) begin
                        m_mode = 3; m_ar = 1;
                    end else if (tick) begin
                        snz_ticks++;
                        if (snz_ticks == int'(SNZ)) begin m_mode = 1; ring_ticks = 0; end
                    end
                end
                default: ;
            endcase
        end
        m_trig = trigger;
    endtask

    // Compare process: every cycle, outputs must match the model.
    initial begin
        m_mode = 0; ring_ticks = 0; snz_ticks = 0; snz_used = 0; m_trig = 0; m_ar = 0;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("model beeping", {7'd0, beeping}, {7'd0, exp_beep()});
            chk("model active", {7'd0, active}, {7'd0, (m_mode == 1 || m_mode == 2)});
            chk("model snoozing", {7'd0, snoozing}, {7'd0, (m_mode == 2)});
            chk("model auto_reset", {7'd0, auto_reset}, {7'd0, m_ar});
            chk("model snooze_cnt", {5'd0, snooze_cnt}, 8'(snz_used));
        end
    end

    task automatic step(input logic t, input logic tr, input logic st, input logic sn);
        @(negedge clk);
        tick = t; trigger = tr; stop = st; snooze = sn;
        @(posedge clk);
        #2;
    endtask

`ifdef ALARM_BEEP_ESCALATE_EN
    bit exp_b [13] = '{1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
`else
    bit exp_b [13] = '{1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
`endif
    bit exp_ar [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    initial begin
        reset = 1'b1; tick = 1'b0; trigger = 1'b0; stop = 1'b0; snooze = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset beeping", {7'd0, beeping}, 8'd0);
        chk("reset active", {7'd0, active}, 8'd0);
        chk("reset snoozing", {7'd0, snoozing}, 8'd0);
        chk("reset auto_reset", {7'd0, auto_reset}, 8'd0);
        chk("reset snooze_cnt", {5'd0, snooze_cnt}, 8'd0);
        @(negedge clk);
        reset = 1'b0;

        // Natural ring: rise, then a tick every second cycle.
        step(0, 1, 0, 0);
        chk("ring beep 0", {7'd0, beeping}, {7'd0, exp_b[0]});
        for (int c = 1; c < 13; c++) begin
            step(logic'(c % 2), 1, 0, 0);
            chk("ring beep seq", {7'd0, beeping}, {7'd0, exp_b[c]});
            chk("ring auto_reset seq", {7'd0, auto_reset}, {7'd0, exp_ar[c]});
        end
        for (int c = 0; c < 10; c++) step(logic'(c % 2), 1, 0, 0);
        chk("no re-ring while held", {7'd0, active}, 8'd0);

        // Snooze at tick 2, then trigger drops mid-snooze.
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 1);
        chk("snooze snoozing", {7'd0, snoozing}, 8'd1);
        chk("snooze cnt", {5'd0, snooze_cnt}, 8'd1);
        chk("snooze beeping", {7'd0, beeping}, 8'd0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("drop cnt cleared", {5'd0, snooze_cnt}, 8'd0);
        chk("drop no auto_reset", {7'd0, auto_reset}, 8'd0);
        chk("drop inactive", {7'd0, active}, 8'd0);

        // Stop coinciding with a tick.
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        chk("stop auto_reset", {7'd0, auto_reset}, 8'd1);
        chk("stop beeping", {7'd0, beeping}, 8'd0);
        chk("stop inactive", {7'd0, active}, 8'd0);

        // Asynchronous reset mid-ring.
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("pre-reset beeping", {7'd0, beeping}, 8'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async reset beeping", {7'd0, beeping}, 8'd0);
        chk("async reset active", {7'd0, active}, 8'd0);
        @(negedge clk);
        reset = 1'b0; trigger = 1'b0;

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset  = ($urandom_range(0, 999) < 3);
            tick   = logic'($urandom_range(0, 1));
            if (trigger) trigger = ($urandom_range(0, 999) >= 15);
            else         trigger = ($urandom_range(0, 99) < 20);
            stop   = ($urandom_range(0, 99) < 2);
            snooze = ($urandom_range(0, 99) < 10);
        end
        @(negedge clk);
        reset = 1'b0; stop = 1'b0; snooze = 1'b0;
        @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
